risk_tile_seq: RTL and testbench
================================

RISK_TILE_SEQ -- requirements
Module: risk_tile_seq

Interface
REQ-001 SHALL have parameter MEM_LAT, default 3, meaning cycles from mem_addr/mem_re issue to valid mem_dat_r.
REQ-002 SHALL have parameter MAX_ROWS, default 4, meaning maximum rows per command.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  in  1, cmd_ready  out  1  command handshake.
REQ-006 SHALL have port cmd_op  in  1  0=load tile to regs, 1=store regs to tile.
REQ-007 SHALL have ports cmd_reg in 5 (first register), cmd_rows in 2 (rows-1), cmd_addr in 15 (base), cmd_stride_x in 14, cmd_stride_y in 14.
REQ-008 SHALL have ports mem_addr out 15, mem_stride_x out 14, mem_re out 1, mem_we out 1, mem_dat_w out 288, mem_dat_r in 288.
REQ-009 SHALL have ports rf_we out 1, rf_waddr out 5, rf_wdata out 288, rf_raddr out 5, rf_rdata in 288 (combinational read).
REQ-010 SHALL have ports busy out 1 and done out 1 (one-cycle pulse).

Function
REQ-011 SHALL implement states IDLE, ISSUE, DRAIN; cmd_ready=1 only in IDLE.
REQ-012 IDLE: on cmd_valid&cmd_ready SHALL latch all cmd_* fields and go to ISSUE next cycle; cmd_valid outside IDLE SHALL be ignored.
REQ-013 ISSUE SHALL issue exactly cmd_rows+1 row requests, one per cycle, no bubbles.
REQ-014 Row r address SHALL be (cmd_addr + r*cmd_stride_y) mod 2^15, formed by accumulation (add zero-extended stride_y per row), wrapping silently.
REQ-015 mem_stride_x SHALL equal the latched cmd_stride_x during ISSUE, 0 otherwise.
REQ-016 Row r register index SHALL be (cmd_reg + r) mod 32.
REQ-017 Load: each ISSUE cycle SHALL assert mem_re with mem_addr; the row tag SHALL enter a MEM_LAT-deep valid/index shift pipe.
REQ-018 Load: when the pipe output is valid, SHALL assert rf_we, rf_waddr=tag index, rf_wdata=mem_dat_r in that same cycle.
REQ-019 Load: after last issue SHALL enter DRAIN, stay until pipe empty, then return to IDLE.
REQ-020 Store: each ISSUE cycle SHALL drive rf_raddr=row index combinationally, mem_dat_w=rf_rdata, mem_we=1, mem_addr=row address; after last row SHALL return to IDLE directly (no DRAIN).
REQ-021 mem_re and mem_we SHALL never be asserted together; both 0 outside ISSUE.
REQ-022 done SHALL pulse in the cycle the state returns to IDLE; busy=1 in ISSUE and DRAIN.
REQ-023 Load of one row: cmd accepted cycle 0, issue cycle 1, rf_we cycle 1+MEM_LAT, done cycle 2+MEM_LAT.
REQ-024 Store of N rows: accepted cycle 0, mem_we cycles 1..N, done cycle N+1.
REQ-025 New command SHALL be acceptable in the cycle done pulses (cmd_ready=1 then).

Reset
REQ-026 Reset SHALL force IDLE, clear the shift pipe (in-flight returns discarded, no rf_we after reset).
REQ-027 Reset values: cmd_ready=1, busy=0, done=0, mem_re=0, mem_we=0, rf_we=0, mem_addr=0, mem_stride_x=0, mem_dat_w=0, rf_waddr=0, rf_wdata=0, rf_raddr=0.
REQ-028 Reset asserted mid-ISSUE or mid-DRAIN SHALL take effect immediately (asynchronous), with no done pulse.

Structure
REQ-029 Package risk_pkg SHALL hold state enum, op encodings (OP_LOAD=0, OP_STORE=1), widths ADDR_W=15, STRIDE_W=14, ROW_W=288, REG_W=5.
REQ-030 The return-tag pipe SHALL be sub-module risk_tag_pipe (depth MEM_LAT, width 1+REG_W, synchronous clear).

Verification
REQ-031 Load rows=4, addr=0x0100, stride_y=0x0040, reg=2, MEM_LAT=3 -> mem_addr 0x0100,0x0140,0x0180,0x01C0 cycles 1-4; rf_we regs 2,3,4,5 cycles 4-7; done cycle 8.
REQ-032 Store rows=2, addr=0x7FF0, stride_y=0x0020, reg=31 -> mem_we addresses 0x7FF0, 0x0010 (wrap); rf_raddr 31, 0; done cycle 3.
REQ-033 cmd_valid held high through a 3-row load -> exactly one command accepted until done, second accepted in done cycle.
REQ-034 Reset asserted cycle 3 of 4-row load -> all outputs reset values immediately, no rf_we in following 5 cycles, cmd_ready=1.
REQ-035 Back-to-back load then store -> mem_re/mem_we never coincident, store issues start the cycle after the load's done cycle.

Source files
------------

// File: rtl/risk_pkg.sv
// Shared types and widths for the tile load/store sequencer.
package risk_pkg;

  localparam int ADDR_W   = 15;
  localparam int STRIDE_W = 14;
  localparam int ROW_W    = 288;
  localparam int REG_W    = 5;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/risk_tag_pipe.sv
// Fixed-latency shift pipe carrying {valid, reg index} tags alongside memory reads.
module risk_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             pending
);

  logic [DEPTH-1:0][WIDTH-1:0] stages;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= '0;
    end else if (clear) begin
      stages <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  // pending ignores the output stage: it is consumed in the current cycle
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending = pending | stages[i][WIDTH-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/risk_tile_seq.sv
// Tile sequencer: moves up to MAX_ROWS strided rows between memory and the register file.
module risk_tile_seq
  import risk_pkg::*;
#(
  parameter int MEM_LAT  = 3,
  parameter int MAX_ROWS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [REG_W-1:0]    cmd_reg,
  input  logic [1:0]          cmd_rows,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [STRIDE_W-1:0] cmd_stride_x,
  input  logic [STRIDE_W-1:0] cmd_stride_y,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [STRIDE_W-1:0] mem_stride_x,
  output logic                mem_re,
  output logic                mem_we,
  output logic [ROW_W-1:0]    mem_dat_w,
  input  logic [ROW_W-1:0]    mem_dat_r,
  output logic                rf_we,
  output logic [REG_W-1:0]    rf_waddr,
  output logic [ROW_W-1:0]    rf_wdata,
  output logic [REG_W-1:0]    rf_raddr,
  input  logic [ROW_W-1:0]    rf_rdata,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] LAST_ROW_MAX = 2'(MAX_ROWS - 1);

  state_t              state;
  logic                op_q;
  logic [1:0]          rows_left;
  logic [ADDR_W-1:0]   cur_addr;
  logic [REG_W-1:0]    cur_reg;
  logic [STRIDE_W-1:0] stride_x_q;
  logic [STRIDE_W-1:0] stride_y_q;
  logic                done_q;

  logic                in_issue;
  logic                is_load;
  logic                pipe_clear;
  logic                pipe_pending;
  logic [REG_W:0]      pipe_in;
  logic [REG_W:0]      pipe_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= OP_LOAD;
      rows_left  <= '0;
      cur_addr   <= '0;
      cur_reg    <= '0;
      stride_x_q <= '0;
      stride_y_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q       <= cmd_op;
            rows_left  <= (cmd_rows > LAST_ROW_MAX) ? LAST_ROW_MAX : cmd_rows;
            cur_addr   <= cmd_addr;
            cur_reg    <= cmd_reg;
            stride_x_q <= cmd_stride_x;
            stride_y_q <= cmd_stride_y;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Address and register index both wrap naturally at their widths
          cur_addr  <= cur_addr + {1'b0, stride_y_q};
          cur_reg   <= cur_reg + 5'd1;
          rows_left <= rows_left - 2'd1;
          if (rows_left == 2'd0) begin
            if (op_q == OP_STORE) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!pipe_pending) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_issue   = (state == ST_ISSUE);
  assign is_load    = (op_q == OP_LOAD);
  assign pipe_clear = (state == ST_IDLE);
  assign pipe_in    = {in_issue && is_load, cur_reg};

  risk_tag_pipe #(
    .DEPTH(MEM_LAT),
    .WIDTH(REG_W + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .clear   (pipe_clear),
    .din     (pipe_in),
    .dout    (pipe_out),
    .pending (pipe_pending)
  );

  // Outputs decode registered state so an asynchronous reset clears them at once
  always_comb begin
    cmd_ready    = (state == ST_IDLE);
    busy         = (state != ST_IDLE);
    done         = done_q;
    mem_re       = in_issue && is_load;
    mem_we       = in_issue && !is_load;
    mem_addr     = in_issue ? cur_addr : '0;
    mem_stride_x = in_issue ? stride_x_q : '0;
    rf_raddr     = mem_we ? cur_reg : '0;
    mem_dat_w    = mem_we ? rf_rdata : '0;
    rf_we        = pipe_out[REG_W];
    rf_waddr     = pipe_out[REG_W] ? pipe_out[REG_W-1:0] : '0;
    rf_wdata     = pipe_out[REG_W] ? mem_dat_r : '0;
  end

endmodule

// File: tb/tb_risk_tile_seq.sv
// Directed bench for risk_tile_seq with a fixed-latency memory and a combinational register file.
module tb_risk_tile_seq;
  import risk_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_op = 1'b0;
  logic [REG_W-1:0]    cmd_reg = '0;
  logic [1:0]          cmd_rows = '0;
  logic [ADDR_W-1:0]   cmd_addr = '0;
  logic [STRIDE_W-1:0] cmd_stride_x = '0;
  logic [STRIDE_W-1:0] cmd_stride_y = '0;
  logic [ADDR_W-1:0]   mem_addr;
  logic [STRIDE_W-1:0] mem_stride_x;
  logic                mem_re;
  logic                mem_we;
  logic [ROW_W-1:0]    mem_dat_w;
  logic [ROW_W-1:0]    mem_dat_r;
  logic                rf_we;
  logic [REG_W-1:0]    rf_waddr;
  logic [ROW_W-1:0]    rf_wdata;
  logic [REG_W-1:0]    rf_raddr;
  logic [ROW_W-1:0]    rf_rdata;
  logic                busy;
  logic                done;

  int errors = 0;
  int checks = 0;
  int accept_count = 0;
  int rf_we_count = 0;
  logic overlap_seen = 1'b0;

  logic [ADDR_W-1:0] lat_a [3] = '{15'h0, 15'h0, 15'h0};
  logic              lat_v [3] = '{1'b0, 1'b0, 1'b0};

  localparam logic [ADDR_W-1:0] LD_ADDR [4] = '{15'h0100, 15'h0140, 15'h0180, 15'h01C0};

  risk_tile_seq #(.MEM_LAT(3), .MAX_ROWS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_reg      (cmd_reg),
    .cmd_rows     (cmd_rows),
    .cmd_addr     (cmd_addr),
    .cmd_stride_x (cmd_stride_x),
    .cmd_stride_y (cmd_stride_y),
    .mem_addr     (mem_addr),
    .mem_stride_x (mem_stride_x),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_dat_w    (mem_dat_w),
    .mem_dat_r    (mem_dat_r),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rf_raddr     (rf_raddr),
    .rf_rdata     (rf_rdata),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [ROW_W-1:0] mem_pat(input logic [ADDR_W-1:0] a);
    return {9{17'h15A5A, a}};
  endfunction

  function automatic logic [ROW_W-1:0] rf_pat(input logic [REG_W-1:0] r);
    return {9{27'h2C0FFEE, r}};
  endfunction

  // Memory returns read data exactly three cycles after the request
  always @(posedge clk) begin
    lat_a[0] <= mem_addr;
    lat_v[0] <= mem_re;
    lat_a[1] <= lat_a[0];
    lat_v[1] <= lat_v[0];
    lat_a[2] <= lat_a[1];
    lat_v[2] <= lat_v[1];
  end

  assign mem_dat_r = lat_v[2] ? mem_pat(lat_a[2]) : '0;
  assign rf_rdata  = rf_pat(rf_raddr);

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) accept_count++;
    if (rf_we) rf_we_count++;
    if (mem_re && mem_we) overlap_seen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [ROW_W-1:0] observed,
                             input logic [ROW_W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command in the current cycle (cycle 0) and leaves the bench in cycle 1
  task automatic applyStimulus(input logic op, input logic [REG_W-1:0] rg, input logic [1:0] rows,
                               input logic [ADDR_W-1:0] addr, input logic [STRIDE_W-1:0] sx,
                               input logic [STRIDE_W-1:0] sy);
    cmd_op       = op;
    cmd_reg      = rg;
    cmd_rows     = rows;
    cmd_addr     = addr;
    cmd_stride_x = sx;
    cmd_stride_y = sy;
    cmd_valid    = 1'b1;
    checkOutput("accept_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, cmd_ready, 1'b1);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_re"}, mem_re, 1'b0);
    checkOutput({tag, "_we"}, mem_we, 1'b0);
    checkOutput({tag, "_rf_we"}, rf_we, 1'b0);
    checkOutput({tag, "_addr"}, mem_addr, '0);
    checkOutput({tag, "_sx"}, mem_stride_x, '0);
    checkOutput({tag, "_dat_w"}, mem_dat_w, '0);
    checkOutput({tag, "_waddr"}, rf_waddr, '0);
    checkOutput({tag, "_wdata"}, rf_wdata, '0);
    checkOutput({tag, "_raddr"}, rf_raddr, '0);
  endtask

  initial begin
    #2;
    checkResetValues("rst");
    tick();
    reset = 1'b0;
    tick();

    // Four-row load: issues cycles 1-4, writebacks cycles 4-7, done cycle 8
    applyStimulus(OP_LOAD, 5'd2, 2'd3, 15'h0100, 14'h0123, 14'h0040);
    for (int c = 1; c <= 8; c++) begin
      checkOutput("ld_re", mem_re, c <= 4);
      checkOutput("ld_busy", busy, c <= 7);
      checkOutput("ld_done", done, c == 8);
      checkOutput("ld_rf_we", rf_we, (c >= 4) && (c <= 7));
      if (c <= 4) begin
        checkOutput("ld_addr", mem_addr, LD_ADDR[c-1]);
        checkOutput("ld_sx", mem_stride_x, 14'h0123);
      end else begin
        checkOutput("ld_sx_idle", mem_stride_x, '0);
      end
      if ((c >= 4) && (c <= 7)) begin
        checkOutput("ld_waddr", rf_waddr, 5'(c - 2));
        checkOutput("ld_wdata", rf_wdata, mem_pat(LD_ADDR[c-4]));
      end
      if (c < 8) tick();
    end
    checkOutput("ld_ready_done", cmd_ready, 1'b1);
    tick();

    // Two-row store with address and register wrap
    applyStimulus(OP_STORE, 5'd31, 2'd1, 15'h7FF0, 14'h0ABC, 14'h0020);
    checkOutput("st1_we", mem_we, 1'b1);
    checkOutput("st1_re", mem_re, 1'b0);
    checkOutput("st1_addr", mem_addr, 15'h7FF0);
    checkOutput("st1_raddr", rf_raddr, 5'd31);
    checkOutput("st1_dat_w", mem_dat_w, rf_pat(5'd31));
    checkOutput("st1_sx", mem_stride_x, 14'h0ABC);
    tick();
    checkOutput("st2_we", mem_we, 1'b1);
    checkOutput("st2_addr", mem_addr, 15'h0010);
    checkOutput("st2_raddr", rf_raddr, 5'd0);
    checkOutput("st2_dat_w", mem_dat_w, rf_pat(5'd0));
    checkOutput("st2_done", done, 1'b0);
    tick();
    checkOutput("st3_done", done, 1'b1);
    checkOutput("st3_we", mem_we, 1'b0);
    checkOutput("st3_busy", busy, 1'b0);
    checkOutput("st_rf_we_none", rf_we, 1'b0);
    tick();

    // cmd_valid held through a three-row load
    cmd_op = OP_LOAD;
    cmd_reg = 5'd10;
    cmd_rows = 2'd2;
    cmd_addr = 15'h0200;
    cmd_stride_x = 14'h0;
    cmd_stride_y = 14'h0001;
    cmd_valid = 1'b1;
    accept_count = 0;
    for (int c = 1; c <= 7; c++) tick();
    checkOutput("hold_accepts_c7", accept_count, 1);
    checkOutput("hold_done_c7", done, 1'b1);
    checkOutput("hold_ready_c7", cmd_ready, 1'b1);
    tick();
    checkOutput("hold_accepts_c8", accept_count, 2);
    checkOutput("hold_re_c8", mem_re, 1'b1);
    checkOutput("hold_addr_c8", mem_addr, 15'h0200);
    cmd_valid = 1'b0;
    rf_we_count = 0;
    for (int c = 9; c <= 14; c++) tick();
    checkOutput("hold2_done_c14", done, 1'b1);
    checkOutput("hold2_rf_we_count", rf_we_count, 3);
    checkOutput("hold2_accepts", accept_count, 2);
    tick();

    // Asynchronous reset in cycle 3 of a four-row load
    applyStimulus(OP_LOAD, 5'd0, 2'd3, 15'h1000, 14'h0005, 14'h0010);
    tick();
    tick();
    checkOutput("rst_mid_re_before", mem_re, 1'b1);
    checkOutput("rst_mid_addr_before", mem_addr, 15'h1020);
    reset = 1'b1;
    #1;
    checkResetValues("rst_mid");
    #1;
    reset = 1'b0;
    rf_we_count = 0;
    accept_count = 0;
    for (int c = 0; c < 5; c++) tick();
    checkOutput("rst_mid_rf_we_count", rf_we_count, 0);
    checkOutput("rst_mid_ready_after", cmd_ready, 1'b1);
    checkOutput("rst_mid_busy_after", busy, 1'b0);

    // Back-to-back: one-row load, store accepted in the load's done cycle
    applyStimulus(OP_LOAD, 5'd7, 2'd0, 15'h0055, 14'h0000, 14'h0100);
    checkOutput("b2b_ld_re", mem_re, 1'b1);
    checkOutput("b2b_ld_addr", mem_addr, 15'h0055);
    tick();
    tick();
    tick();
    checkOutput("b2b_ld_rf_we", rf_we, 1'b1);
    checkOutput("b2b_ld_waddr", rf_waddr, 5'd7);
    checkOutput("b2b_ld_wdata", rf_wdata, mem_pat(15'h0055));
    checkOutput("b2b_ld_done_early", done, 1'b0);
    tick();
    checkOutput("b2b_ld_done", done, 1'b1);
    applyStimulus(OP_STORE, 5'd20, 2'd1, 15'h0300, 14'h0011, 14'h0008);
    checkOutput("b2b_st1_we", mem_we, 1'b1);
    checkOutput("b2b_st1_re", mem_re, 1'b0);
    checkOutput("b2b_st1_addr", mem_addr, 15'h0300);
    checkOutput("b2b_st1_raddr", rf_raddr, 5'd20);
    checkOutput("b2b_st1_dat_w", mem_dat_w, rf_pat(5'd20));
    tick();
    checkOutput("b2b_st2_addr", mem_addr, 15'h0308);
    checkOutput("b2b_st2_raddr", rf_raddr, 5'd21);
    tick();
    checkOutput("b2b_st_done", done, 1'b1);
    checkOutput("b2b_st_we_off", mem_we, 1'b0);
    tick();

    checkOutput("no_re_we_overlap", overlap_seen, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
